// File: rtl/ysyx_23060187_fetch_seq.sv
// ysyx_23060187_fetch_seq
// Multi-cycle fetch sequencer that owns the core's program counter.
// It fetches one instruction over a valid/ready request plus a one-cycle
// response strobe. It then holds the instruction for decode/execute until
// exu_done arrives, and chooses the next PC by priority:
// trap > mret > redirect > pc+4.
//
// Ports:
//   clk, rst           clock; synchronous active-high reset
//   imem_req_*         fetch request (valid/ready, addr == pc)
//   imem_resp_*        fetch response (valid strobe, data, bus error)
//   inst_valid/inst/pc instruction presented to decode/execute
//   exu_done           completion of the current instruction
//   redir_*/trap_*/mret_valid/mepc   next-PC sources, sampled with exu_done
//   halt_req/halted    park after the current instruction
//   fetch_fault/fault_addr           pending fault, cleared by trap_valid
//   retire_cnt         retired-instruction counter (wraps)
module ysyx_23060187_fetch_seq #(
    parameter logic [31:0] RESET_PC = 32'h80000000,
    parameter int unsigned XLEN     = 32
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [XLEN-1:0] imem_resp_data,
    input  logic            imem_resp_err,
    output logic            inst_valid,
    output logic [XLEN-1:0] inst,
    output logic [XLEN-1:0] pc,
    input  logic            exu_done,
    input  logic            redir_valid,
    input  logic [XLEN-1:0] redir_target,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_vector,
    input  logic            mret_valid,
    input  logic [XLEN-1:0] mepc,
    input  logic            halt_req,
    output logic            halted,
    output logic            fetch_fault,
    output logic [XLEN-1:0] fault_addr,
    output logic [XLEN-1:0] retire_cnt
);

    typedef enum logic [2:0] {
        S_REQ   = 3'd0,
        S_WAIT  = 3'd1,
        S_EXEC  = 3'd2,
        S_HALT  = 3'd3,
        S_FAULT = 3'd4
    } state_t;

    state_t          state;
    logic [XLEN-1:0] next_pc;
    logic            next_checked;
    logic            next_misaligned;

    // Next-PC selection for the EXEC state; only mret/redirect targets are
    // alignment-checked, trap vectors are trusted.
    always_comb begin
        next_pc      = pc + XLEN'(4);
        next_checked = 1'b0;
        if (trap_valid) begin
            next_pc = trap_vector;
        end else if (mret_valid) begin
            next_pc      = mepc;
            next_checked = 1'b1;
        end else if (redir_valid) begin
            next_pc      = redir_target;
            next_checked = 1'b1;
        end
        next_misaligned = next_checked && (next_pc[1:0] != 2'b00);
    end

    // State decode; rst forces the strobes low while it is asserted.
    assign imem_req_valid = !rst && (state == S_REQ);
    assign inst_valid     = !rst && (state == S_EXEC);
    assign halted         = !rst && (state == S_HALT);
    assign fetch_fault    = !rst && (state == S_FAULT);
    assign imem_req_addr  = pc;

    // Sequencer state and architectural registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_REQ;
            pc         <= RESET_PC;
            inst       <= '0;
            fault_addr <= '0;
            retire_cnt <= '0;
        end else begin
            case (state)
                S_REQ: begin
                    if (imem_req_ready) begin
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_resp_valid) begin
                        if (imem_resp_err) begin
                            fault_addr <= pc;
                            state      <= S_FAULT;
                        end else begin
                            inst  <= imem_resp_data;
                            state <= S_EXEC;
                        end
                    end
                end
                S_EXEC: begin
                    if (exu_done) begin
                        if (next_misaligned) begin
                            fault_addr <= next_pc;
                            state      <= S_FAULT;
                        end else begin
                            pc <= next_pc;
                            // A trapped instruction does not retire.
                            if (!trap_valid) begin
                                retire_cnt <= retire_cnt + XLEN'(1);
                            end
                            state <= halt_req ? S_HALT : S_REQ;
                        end
                    end
                end
                S_HALT: begin
                    if (trap_valid) begin
                        pc    <= trap_vector;
                        state <= S_REQ;
                    end else if (!halt_req) begin
                        state <= S_REQ;
                    end
                end
                S_FAULT: begin
                    if (trap_valid) begin
                        pc    <= trap_vector;
                        state <= S_REQ;
                    end
                end
                default: state <= S_REQ;
            endcase
        end
    end

endmodule

// File: doc/ysyx_23060187_fetch_seq.md
Name: ysyx_23060187_fetch_seq

Overview:
Multi-cycle fetch sequencer that owns the program counter of the ysyx_23060187 core. It issues instruction-memory requests over a valid/ready handshake and holds the fetched instruction for decode/execute until the execute unit signals completion. It then selects the next PC by fixed priority: trap > mret > jump/branch redirect > sequential. It also provides fetch-fault signalling, a halt hook, and a retired-instruction counter.

Parameters:
RESET_PC, 32'h80000000, PC value loaded on reset.
XLEN, 32, address/data width; only 32 is supported.

Ports:
clk  input  1  clock; all state changes on posedge.
rst  input  1  synchronous active-high reset.
imem_req_valid  output  1  fetch request valid.
imem_req_ready  input  1  memory accepts request.
imem_req_addr  output  32  fetch address; equals pc.
imem_resp_valid  input  1  response strobe, one cycle.
imem_resp_data  input  32  instruction word.
imem_resp_err  input  1  bus error qualifying resp_valid.
inst_valid  output  1  inst/pc are valid for decode.
inst  output  32  latched instruction.
pc  output  32  current PC.
exu_done  input  1  current instruction has completed; redirect inputs are sampled this cycle.
redir_valid  input  1  jal/jalr/taken branch.
redir_target  input  32  redirect target, already computed.
trap_valid  input  1  enter trap.
trap_vector  input  32  mtvec target.
mret_valid  input  1  return from trap.
mepc  input  32  mret target.
halt_req  input  1  stop fetching after the current instruction.
halted  output  1  sequencer is parked.
fetch_fault  output  1  fault pending; waits for trap_valid.
fault_addr  output  32  faulting address.
retire_cnt  output  32  retired-instruction count.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: pc=RESET_PC, state=REQ, inst=0, retire_cnt=0, fault_addr=0. While rst is high, imem_req_valid, inst_valid, halted and fetch_fault are all 0.
- Reset mid-operation aborts any transaction. A response that arrives in REQ after reset is ignored.
- States: REQ, WAIT, EXEC, HALT, FAULT.
- REQ:
  - imem_req_valid=1, addr=pc.
  - imem_req_ready=1 -> WAIT. Otherwise stay; addr is held stable.
  - First request is visible in the cycle after rst deasserts.
- WAIT:
  - imem_req_valid=0.
  - resp_valid && !err -> latch inst=resp_data, go to EXEC.
  - resp_valid && err -> fault_addr=pc, go to FAULT.
  - Zero-wait memory (ready and resp in consecutive cycles) gives a minimum of 3 cycles per instruction: REQ, WAIT, EXEC.
- EXEC:
  - inst_valid=1. Waits indefinitely for exu_done.
  - On exu_done, next PC by priority:
    1. trap_valid -> trap_vector.
    2. mret_valid -> mepc.
    3. redir_valid -> redir_target.
    4. Otherwise pc+4, modulo 2^32; 32'hFFFFFFFC wraps to 0.
  - Simultaneous requests resolve by that priority only.
  - Misaligned target ([1:0]!=0) on the redir or mret path -> pc unchanged, fault_addr=target, go to FAULT.
  - trap_vector is never checked for alignment.
  - retire_cnt increments on exu_done unless trap_valid is set or the selected target faults. It wraps at 2^32.
  - Next state: FAULT if faulted; else HALT if halt_req; else REQ.
- HALT:
  - halted=1, no requests, pc holds the next PC.
  - halt_req=0 -> REQ.
  - trap_valid in HALT -> pc=trap_vector, go to REQ (interrupt wake).
- FAULT:
  - fetch_fault=1 and fault_addr held; no requests.
  - trap_valid -> pc=trap_vector, fetch_fault drops next cycle, go to REQ.
  - Other inputs are ignored.
- exu_done, redir_valid and mret_valid outside EXEC are ignored.
- inst holds its value outside EXEC and is only updated in WAIT.

Test Plan:
1. Reset then sequential: rst for 2 cycles; memory ready=1 with 1-cycle response -> requests at 0x80000000, 0x80000004, 0x80000008. After 3 exu_done, retire_cnt=3 and inst_valid is high in every third cycle.
2. Backpressure/priority: hold req_ready=0 for 5 cycles -> addr stable at 0x80000000. In EXEC, exu_done with redir_valid=1 (0x80000100), mret_valid=1 (mepc=0x80000200) and trap_valid=1 (vector=0x80000400) -> next request 0x80000400 and retire_cnt unchanged.
3. Misaligned redirect: redir_target=0x80000102 -> fetch_fault=1, fault_addr=0x80000102, pc stays. Apply trap_valid with vector 0x80000040 -> next request 0x80000040 and fetch_fault clears.
4. Bus error: resp_err=1 on fetch at 0x80000010 -> FAULT with fault_addr=0x80000010, no inst_valid, no further requests until trap_valid.
5. Halt/wake/reset: halt_req=1 at exu_done -> halted=1, no requests. Drop halt_req -> fetch resumes at pc+4. Assert rst in WAIT -> next request is at 0x80000000 and a stale response is ignored.
6. Wrap: force pc=0xFFFFFFFC via redirect, then exu_done without redirect -> next request at 0x00000000.
